// File: rtl/lock_timer_ctrl.sv
// Programmable lockout/session timer: prescaled tick, loadable limit, one-shot or auto-reload expiry.
// Optional build macro LOCK_TIMER_LEVEL_START_EN selects legacy level-sensitive start.
module lock_timer_ctrl #(
    parameter int CNT_W         = 32,
    parameter int PRESCALE      = 1,
    parameter int DEFAULT_LIMIT = 1,
    parameter int EXP_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             pause,
    input  logic             mode,
    input  logic             load_limit,
    input  logic [CNT_W-1:0] limit_in,
    output logic             time_up,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [EXP_W-1:0] expire_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIM_RST = CNT_W'(DEFAULT_LIMIT);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [CNT_W-1:0]   lim_r, lim_s;
    logic [PRE_W-1:0]   pre_r, pre_s;
    logic               time_up_r, time_up_s;
    logic [EXP_W-1:0]   expire_cnt_r, expire_cnt_s;
    logic [CNT_W-1:0]   remaining_r, remaining_s;
    logic               busy_r;
    logic               restart_s;
    logic               drop_s;

    function automatic logic [EXP_W-1:0] sat_inc(input logic [EXP_W-1:0] val);
        if (&val) begin
            return val;
        end else begin
            return val + EXP_W'(1);
        end
    endfunction

    // Ticks left; a limit lowered below the current count reads as zero left.
    function automatic logic [CNT_W-1:0] calc_remaining(input state_t st,
                                                        input logic [CNT_W-1:0] cnt,
                                                        input logic [CNT_W-1:0] lim);
        case (st)
            IDLE:    return lim;
            RUN:     return (cnt >= lim) ? {CNT_W{1'b0}} : (lim - cnt);
            DONE:    return {CNT_W{1'b0}};
            default: return {CNT_W{1'b0}};
        endcase
    endfunction

`ifdef LOCK_TIMER_LEVEL_START_EN
    assign restart_s = 1'b0;
    assign drop_s    = ~start;
`else
    assign restart_s = start;
    assign drop_s    = 1'b0;
`endif

    // Next-state computation: cancel > start > tick.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        pre_s        = pre_r;
        time_up_s    = time_up_r;
        expire_cnt_s = expire_cnt_r;
        if (load_limit) begin
            lim_s = (limit_in == {CNT_W{1'b0}}) ? CNT_ONE : limit_in;
        end else begin
            lim_s = lim_r;
        end

        if (cancel) begin
            state_s   = IDLE;
            count_s   = {CNT_W{1'b0}};
            pre_s     = {PRE_W{1'b0}};
            time_up_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s   = RUN;
                        count_s   = {CNT_W{1'b0}};
                        pre_s     = {PRE_W{1'b0}};
                        time_up_s = 1'b0;
                    end else begin
                        time_up_s = 1'b0;
                    end
                end
                RUN: begin
                    time_up_s = 1'b0;
                    if (restart_s) begin
                        count_s = {CNT_W{1'b0}};
                        pre_s   = {PRE_W{1'b0}};
                    end else if (drop_s) begin
                        state_s = IDLE;
                        count_s = {CNT_W{1'b0}};
                        pre_s   = {PRE_W{1'b0}};
                    end else if (pause) begin
                        pre_s = pre_r;
                    end else if (pre_r == PRE_MAX) begin
                        pre_s = {PRE_W{1'b0}};
                        // Comparing against lim-1 avoids overflow of count+1.
                        if (count_r >= (lim_r - CNT_ONE)) begin
                            time_up_s    = 1'b1;
                            expire_cnt_s = sat_inc(expire_cnt_r);
                            if (mode) begin
                                count_s = {CNT_W{1'b0}};
                            end else begin
                                state_s = DONE;
                                count_s = lim_r;
                            end
                        end else begin
                            count_s = count_r + CNT_ONE;
                        end
                    end else begin
                        pre_s = pre_r + PRE_W'(1);
                    end
                end
                DONE: begin
                    if (restart_s) begin
                        state_s   = RUN;
                        count_s   = {CNT_W{1'b0}};
                        pre_s     = {PRE_W{1'b0}};
                        time_up_s = 1'b0;
                    end else if (drop_s) begin
                        state_s   = IDLE;
                        count_s   = {CNT_W{1'b0}};
                        pre_s     = {PRE_W{1'b0}};
                        time_up_s = 1'b0;
                    end else begin
                        time_up_s = 1'b1;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    count_s   = {CNT_W{1'b0}};
                    pre_s     = {PRE_W{1'b0}};
                    time_up_s = 1'b0;
                end
            endcase
        end
        remaining_s = calc_remaining(state_s, count_s, lim_s);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            count_r      <= {CNT_W{1'b0}};
            pre_r        <= {PRE_W{1'b0}};
            lim_r        <= LIM_RST;
            time_up_r    <= 1'b0;
            busy_r       <= 1'b0;
            expire_cnt_r <= {EXP_W{1'b0}};
            remaining_r  <= LIM_RST;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            pre_r        <= pre_s;
            lim_r        <= lim_s;
            time_up_r    <= time_up_s;
            busy_r       <= (state_s == RUN);
            expire_cnt_r <= expire_cnt_s;
            remaining_r  <= remaining_s;
        end
    end

    assign time_up    = time_up_r;
    assign busy       = busy_r;
    assign remaining  = remaining_r;
    assign expire_cnt = expire_cnt_r;

endmodule

// File: tb/tb_lock_timer_ctrl.sv
// Directed bench for lock_timer_ctrl; three instances share stimulus (PRESCALE=1, PRESCALE=4, EXP_W=2).
module tb_lock_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, cancel, pause, mode, load_limit;
    logic [31:0] limit_in;

    logic        a_time_up, a_busy;
    logic [31:0] a_rem;
    logic [7:0]  a_exp;
    logic        b_time_up, b_busy;
    logic [15:0] b_rem;
    logic [7:0]  b_exp;
    logic        c_time_up, c_busy;
    logic [15:0] c_rem;
    logic [1:0]  c_exp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lock_timer_ctrl #(.CNT_W(32), .PRESCALE(1), .DEFAULT_LIMIT(1), .EXP_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .pause(pause), .mode(mode),
        .load_limit(load_limit), .limit_in(limit_in),
        .time_up(a_time_up), .busy(a_busy), .remaining(a_rem), .expire_cnt(a_exp));

    lock_timer_ctrl #(.CNT_W(16), .PRESCALE(4), .DEFAULT_LIMIT(1), .EXP_W(8)) u_b (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .pause(pause), .mode(mode),
        .load_limit(load_limit), .limit_in(limit_in[15:0]),
        .time_up(b_time_up), .busy(b_busy), .remaining(b_rem), .expire_cnt(b_exp));

    lock_timer_ctrl #(.CNT_W(16), .PRESCALE(1), .DEFAULT_LIMIT(1), .EXP_W(2)) u_c (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .pause(pause), .mode(mode),
        .load_limit(load_limit), .limit_in(limit_in[15:0]),
        .time_up(c_time_up), .busy(c_busy), .remaining(c_rem), .expire_cnt(c_exp));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cancel = 1'b0; pause = 1'b0; mode = 1'b0;
        load_limit = 1'b0; limit_in = 32'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [31:0] v);
        limit_in = v; load_limit = 1'b1;
        tick();
        load_limit = 1'b0;
    endtask

    // Start sampled at this edge; level builds keep start held.
    task automatic pulse_start();
        start = 1'b1;
        tick();
`ifndef LOCK_TIMER_LEVEL_START_EN
        start = 1'b0;
`endif
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_time_up !== 1'b0) begin errors++; $display("FAIL reset_time_up got=%0b exp=0", a_time_up); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", a_busy); end
        checks++; if (a_exp !== 8'd0) begin errors++; $display("FAIL reset_expire_cnt got=%0d exp=0", a_exp); end
        checks++; if (a_rem !== 32'd1) begin errors++; $display("FAIL reset_remaining got=%0d exp=1", a_rem); end
    endtask

    task automatic test_oneshot();
        do_reset();
        pulse_start();
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy0 got=%0b exp=1", a_busy); end
        tick();
        checks++; if (a_time_up !== 1'b1) begin errors++; $display("FAIL oneshot_time_up got=%0b exp=1", a_time_up); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy1 got=%0b exp=0", a_busy); end
        checks++; if (a_exp !== 8'd1) begin errors++; $display("FAIL oneshot_expire_cnt got=%0d exp=1", a_exp); end
        checks++; if (a_rem !== 32'd0) begin errors++; $display("FAIL oneshot_remaining got=%0d exp=0", a_rem); end
        tick();
        checks++; if (a_time_up !== 1'b1) begin errors++; $display("FAIL oneshot_held got=%0b exp=1", a_time_up); end
    endtask

    task automatic test_prescale();
        logic [15:0] exp_rem;
        do_reset();
        load(32'd3);
        pulse_start();
        checks++; if (b_rem !== 16'd3) begin errors++; $display("FAIL prescale_rem0 got=%0d exp=3", b_rem); end
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (b_time_up !== (e == 12)) begin
                errors++; $display("FAIL prescale_time_up edge=%0d got=%0b exp=%0b", e, b_time_up, (e == 12));
            end
            if (e % 4 == 0) begin
                exp_rem = 16'(3 - e / 4);
                checks++;
                if (b_rem !== exp_rem) begin
                    errors++; $display("FAIL prescale_rem edge=%0d got=%0d exp=%0d", e, b_rem, exp_rem);
                end
            end
        end
        checks++; if (b_exp !== 8'd1) begin errors++; $display("FAIL prescale_expire_cnt got=%0d exp=1", b_exp); end
    endtask

    task automatic test_autoreload();
        do_reset();
        load(32'd5);
        mode = 1'b1;
        pulse_start();
        for (int e = 1; e <= 25; e++) begin
            tick();
            checks++;
            if (a_time_up !== (e % 5 == 0) || a_busy !== 1'b1) begin
                errors++; $display("FAIL autoreload edge=%0d time_up=%0b busy=%0b exp_time_up=%0b", e, a_time_up, a_busy, (e % 5 == 0));
            end
            if (e == 20) begin
                checks++; if (a_exp !== 8'd4) begin errors++; $display("FAIL autoreload_cnt20 got=%0d exp=4", a_exp); end
            end
            if (e == 7) begin
                checks++; if (a_rem !== 32'd3) begin errors++; $display("FAIL autoreload_rem7 got=%0d exp=3", a_rem); end
            end
        end
        checks++; if (a_exp !== 8'd5) begin errors++; $display("FAIL autoreload_cnt25 got=%0d exp=5", a_exp); end
        checks++; if (c_exp !== 2'd3) begin errors++; $display("FAIL expire_saturate got=%0d exp=3", c_exp); end
        checks++; if (c_time_up !== 1'b1 || c_busy !== 1'b1 || c_rem !== 16'd5) begin
            errors++; $display("FAIL autoreload_c got tu=%0b busy=%0b rem=%0d exp tu=1 busy=1 rem=5", c_time_up, c_busy, c_rem);
        end
        cancel = 1'b1; mode = 1'b0;
        tick();
        cancel = 1'b0;
        checks++; if (a_busy !== 1'b0 || a_time_up !== 1'b0) begin
            errors++; $display("FAIL autoreload_cancel got busy=%0b tu=%0b exp busy=0 tu=0", a_busy, a_time_up);
        end
    endtask

    task automatic test_pause();
        do_reset();
        load(32'd10);
        pulse_start();
        for (int e = 1; e <= 17; e++) begin
            pause = (e >= 4 && e <= 10);
            tick();
            if (e == 10) begin
                checks++; if (a_rem !== 32'd7) begin errors++; $display("FAIL pause_rem got=%0d exp=7", a_rem); end
            end
            if (e == 16) begin
                checks++; if (a_time_up !== 1'b0) begin errors++; $display("FAIL pause_early got=%0b exp=0", a_time_up); end
            end
        end
        pause = 1'b0;
        checks++; if (a_time_up !== 1'b1) begin errors++; $display("FAIL pause_expiry got=%0b exp=1", a_time_up); end
    endtask

    task automatic test_cancel_start();
        do_reset();
        load(32'd10);
        pulse_start();
        tick(); tick();
        cancel = 1'b1; start = 1'b1;
        tick();
        cancel = 1'b0; start = 1'b0;
        checks++; if (a_busy !== 1'b0 || a_time_up !== 1'b0 || a_rem !== 32'd10) begin
            errors++; $display("FAIL cancel_start got busy=%0b tu=%0b rem=%0d exp 0 0 10", a_busy, a_time_up, a_rem);
        end
    endtask

    task automatic test_restart();
        do_reset();
        load(32'd10);
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        pulse_start();
        checks++; if (a_rem !== 32'd10 || a_busy !== 1'b1) begin
            errors++; $display("FAIL restart_rem got rem=%0d busy=%0b exp 10 1", a_rem, a_busy);
        end
        for (int i = 0; i < 9; i++) tick();
        checks++; if (a_time_up !== 1'b0) begin errors++; $display("FAIL restart_early got=%0b exp=0", a_time_up); end
        tick();
        checks++; if (a_time_up !== 1'b1) begin errors++; $display("FAIL restart_expiry got=%0b exp=1", a_time_up); end
        do_reset();
        load(32'd3);
        pulse_start();
        tick(); tick();
        pulse_start();
        checks++; if (a_time_up !== 1'b0 || a_busy !== 1'b1 || a_rem !== 32'd3 || a_exp !== 8'd0) begin
            errors++; $display("FAIL restart_suppress got tu=%0b busy=%0b rem=%0d cnt=%0d exp 0 1 3 0", a_time_up, a_busy, a_rem, a_exp);
        end
    endtask

    task automatic test_limit_edges();
        do_reset();
        load(32'd5);
        checks++; if (a_rem !== 32'd5) begin errors++; $display("FAIL limit_load5 got=%0d exp=5", a_rem); end
        load(32'd0);
        checks++; if (a_rem !== 32'd1) begin errors++; $display("FAIL limit_zero got=%0d exp=1", a_rem); end
        load(32'd10);
        pulse_start();
        for (int i = 0; i < 6; i++) tick();
        checks++; if (a_rem !== 32'd4) begin errors++; $display("FAIL limit_count6 got=%0d exp=4", a_rem); end
        pause = 1'b1;
        load(32'd4);
        pause = 1'b0;
        checks++; if (a_time_up !== 1'b0 || a_busy !== 1'b1) begin
            errors++; $display("FAIL limit_lower_load got tu=%0b busy=%0b exp 0 1", a_time_up, a_busy);
        end
        tick();
        checks++; if (a_time_up !== 1'b1 || a_busy !== 1'b0 || a_exp !== 8'd1 || a_rem !== 32'd0) begin
            errors++; $display("FAIL limit_lower_expiry got tu=%0b busy=%0b cnt=%0d rem=%0d exp 1 0 1 0", a_time_up, a_busy, a_exp, a_rem);
        end
    endtask

    task automatic test_level_start();
        do_reset();
        load(32'd3);
        start = 1'b1;
        tick();
        checks++; if (a_busy !== 1'b1 || a_rem !== 32'd3) begin
            errors++; $display("FAIL level_enter got busy=%0b rem=%0d exp 1 3", a_busy, a_rem);
        end
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (a_time_up !== (e >= 3)) begin
                errors++; $display("FAIL level_time_up edge=%0d got=%0b exp=%0b", e, a_time_up, (e >= 3));
            end
        end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL level_no_restart got=%0b exp=0", a_busy); end
        start = 1'b0;
        tick();
        checks++; if (a_time_up !== 1'b0 || a_busy !== 1'b0 || a_rem !== 32'd3) begin
            errors++; $display("FAIL level_drop got tu=%0b busy=%0b rem=%0d exp 0 0 3", a_time_up, a_busy, a_rem);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        load(32'd2);
        mode = 1'b1;
        pulse_start();
        tick(); tick(); tick();
        checks++; if (a_exp !== 8'd1 || a_busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre got cnt=%0d busy=%0b exp 1 1", a_exp, a_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; mode = 1'b0;
        checks++; if (a_busy !== 1'b0 || a_time_up !== 1'b0 || a_rem !== 32'd1 || a_exp !== 8'd0) begin
            errors++; $display("FAIL rst_mid got busy=%0b tu=%0b rem=%0d cnt=%0d exp 0 0 1 0", a_busy, a_time_up, a_rem, a_exp);
        end
    endtask

    initial begin
        test_reset();
`ifdef LOCK_TIMER_LEVEL_START_EN
        test_level_start();
`else
        test_oneshot();
        test_prescale();
        test_autoreload();
        test_pause();
        test_restart();
        test_limit_edges();
`endif
        test_cancel_start();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
